instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Instruction-fetch front end of `pipeline_processor`. It owns the program counter and issues word reads to a synchronous instruction memory. Returned instructions are buffered in a small prefetch queue and presented to the decode stage over a valid/ready handshake. A redirect input, driven by branch/jump resolution, flushes everything in flight and restarts fetch at a new PC.

## Interface
Parameters:
- `ADDR_W`, 8, PC / instruction-memory word-address width
- `INSTR_W`, 16, instruction width
- `FQ_DEPTH`, 4, prefetch queue entries (power of two, ≥2)
- `RESET_PC`, 0, PC loaded on reset

Ports:
- `clk`  in  1  single clock; all state on rising edge
- `reset`  in  1  synchronous, active-high
- `imem_en`  out  1  read request this cycle
- `imem_addr`  out  ADDR_W  word address of the request
- `imem_rdata`  in  INSTR_W  read data, valid the cycle after `imem_en`
- `redirect_valid`  in  1  flush and restart fetch
- `redirect_pc`  in  ADDR_W  new fetch address
- `id_valid`  out  1  queue head valid to decode
- `id_instr`  out  INSTR_W  head instruction
- `id_pc`  out  ADDR_W  PC of head instruction
- `id_ready`  in  1  decode accepts head
- `perf_stall_cnt`  out  32  fetch-stall cycle counter (see Configuration)

## Operation
- State: `pc`, `inflight` (1 bit: request issued last cycle, response due now), `epoch`-free flush via `inflight` kill, queue with `count` (0..FQ_DEPTH).
- Issue rule: `imem_en = !reset && !redirect_valid && (count + inflight < FQ_DEPTH)`. `imem_addr = pc`. On issue, `pc <= pc + 1`, modulo 2^ADDR_W (wraps from all-ones to 0).
- Response: when `inflight` is 1 and not killed, push {`pc` of request, `imem_rdata`} into the queue. The PC travels in a registered copy taken at issue.
- Pop: when `id_valid && id_ready`, the head is removed. Push and pop in the same cycle leave `count` unchanged. Pop while empty has no effect.
- Overflow cannot occur by construction. The credit check counts the in-flight request.
- Redirect (cycle N):
  - Queue cleared, `count <= 0`.
  - The in-flight response due in cycle N is discarded.
  - `pc <= redirect_pc`.
  - No request is issued in cycle N.
  - A decode handshake in cycle N still completes. Decode owns that instruction.
- Reset has priority over redirect. It forces `pc <= RESET_PC`, `count <= 0` and `inflight <= 0`, and drops any response.

## Timing
- Reset values: `imem_en` 0 while `reset` is high; `imem_addr` = RESET_PC; `id_valid` 0; `id_instr` 0; `id_pc` 0; `perf_stall_cnt` 0.
- Fetch latency: a request in cycle t gives data on `imem_rdata` in t+1. The entry is written at the end of t+1, and `id_valid` is first high in t+2.
- First cycle after reset deasserts is cycle 0:
  - Cycle 0: `imem_en`=1, addr RESET_PC.
  - Cycle 2: `id_valid`=1, `id_pc`=RESET_PC.
- Redirect at cycle N:
  - N+1: `imem_en`=1 with addr `redirect_pc`.
  - N+3: `id_valid` first high.
- Steady state with `id_ready` held high: one instruction per cycle, no bubbles.
- `id_*` outputs are driven from registers (the queue head). They have no combinational path from `id_ready` or `imem_rdata`.
- `id_instr`/`id_pc` hold stable while `id_valid && !id_ready`.

## Configuration
- Macro `FETCH_PERF_EN`.
- Defined: `perf_stall_cnt` increments, saturating at 2^32−1, each cycle in which `id_valid`=0 and `reset`=0 and `redirect_valid`=0. Reset clears it.
- Undefined: the counter logic is absent. The port is tied to 0.

## Structure
- Package `fetch_pkg`:
  - Default widths `ADDR_W_DEF`/`INSTR_W_DEF`.
  - Packed struct `fetch_entry_t` {pc, instr}.
  - Constant `RESET_PC_DEF`.
- Sub-module `fetch_queue`:
  - Synchronous FIFO of `fetch_entry_t`, depth FQ_DEPTH.
  - Ports: push, pop, flush, count, head. Head is registered.
  - Wrapping read/write pointers of log2(FQ_DEPTH) bits.
- The top level holds the PC, the in-flight tracking, the issue/credit logic and the perf counter.

## Test plan
- Reset then free run, memory word i holds 0x1000+i, `id_ready`=1 → cycle 2 `id_pc`=0/`id_instr`=0x1000, then one per cycle, PCs 1, 2, 3… in order.
- `id_ready`=0 from cycle 2 → `imem_en` stops after `count`+`inflight`=4. After that, 4 entries with PC 0..3 are held stable. Release → PCs 0..3 drain back-to-back, then fetch resumes at PC 4.
- `redirect_valid`=1, `redirect_pc`=0x40 while the queue holds 3 entries and a request is in flight → next cycle `imem_addr`=0x40, no stale PC reaches decode, first `id_pc`=0x40 at N+3.
- Start with RESET_PC=0xFE and ADDR_W=8 → `id_pc` sequence 0xFE, 0xFF, 0x00, 0x01.
- Assert `reset` for one cycle mid-stream with the queue full and `redirect_valid` high → next cycle `id_valid`=0, `count`=0, fetch restarts at RESET_PC (redirect ignored).
- With `FETCH_PERF_EN`: hold `id_ready`=1 from reset → `perf_stall_cnt`=2 after the first instruction appears (cycles 0, 1). Without the macro it reads 0 throughout.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and default widths for the instruction-fetch front end.
package fetch_pkg;

    localparam int ADDR_W_DEF  = 8;
    localparam int INSTR_W_DEF = 16;
    localparam logic [ADDR_W_DEF-1:0] RESET_PC_DEF = '0;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0]  pc;
        logic [INSTR_W_DEF-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO between instruction memory and decode; head is read straight
// from the storage registers and forced to zero while the queue is empty.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  entry_t                 push_data,
    input  logic                   pop,
    input  logic                   flush,
    output logic [$clog2(DEPTH):0] count,
    output entry_t                 head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               do_pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop && (count_q != '0);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (push)   wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + CNT_W'(push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush && !reset) mem_q[wr_ptr_q] <= push_data;
    end

    assign count = count_q;
    assign head  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch front end: PC, single-outstanding memory request, credit-based issue.
// Optional stall counter is built only when FETCH_PERF_EN is defined.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int INSTR_W  = INSTR_W_DEF,
    parameter int FQ_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_en,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               id_valid,
    output logic [INSTR_W-1:0] id_instr,
    output logic [ADDR_W-1:0]  id_pc,
    input  logic               id_ready,
    output logic [31:0]        perf_stall_cnt
);

    localparam int CNT_W = $clog2(FQ_DEPTH) + 1;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] req_pc_q, req_pc_d;
    logic              inflight_q, inflight_d;
    logic              issue, push, pop;
    logic [CNT_W-1:0]  count;
    entry_t            push_data, head;

    always_comb begin
        // The outstanding request already owns a slot, so it counts against credit.
        issue = !reset && !redirect_valid &&
                ((CNT_W+1)'(count) + (CNT_W+1)'(inflight_q) < (CNT_W+1)'(FQ_DEPTH));
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        inflight_d = issue;
        if (redirect_valid) begin
            pc_d = redirect_pc;
        end else if (issue) begin
            pc_d     = pc_q + 1'b1;
            req_pc_d = pc_q;
        end
        push            = inflight_q && !redirect_valid && !reset;
        pop             = id_valid && id_ready;
        push_data.pc    = req_pc_q;
        push_data.instr = imem_rdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            inflight_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
        end
        req_pc_q <= req_pc_d;
    end

    fetch_queue #(
        .DEPTH   (FQ_DEPTH),
        .entry_t (entry_t)
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (redirect_valid),
        .count     (count),
        .head      (head)
    );

    assign imem_en   = issue;
    assign imem_addr = reset ? RESET_PC : pc_q;
    assign id_valid  = (count != '0);
    assign id_pc     = head.pc;
    assign id_instr  = head.instr;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if (!id_valid && !redirect_valid && (perf_q != '1)) perf_d = perf_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) perf_q <= '0;
        else       perf_q <= perf_d;
    end

    assign perf_stall_cnt = perf_q;
`else
    assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed, table-driven bench for instr_fetch_unit with a synchronous memory model.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_en;
    logic [7:0]  imem_addr;
    logic [15:0] imem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [7:0]  redirect_pc = '0;
    logic        id_valid;
    logic [15:0] id_instr;
    logic [7:0]  id_pc;
    logic        id_ready = 1'b1;
    logic [31:0] perf_stall_cnt;

    logic        imem_en2;
    logic [7:0]  imem_addr2;
    logic [15:0] imem_rdata2 = '0;
    logic        id_valid2;
    logic [15:0] id_instr2;
    logic [7:0]  id_pc2;
    logic [31:0] perf_stall_cnt2;

    int checks = 0;
    int failures = 0;

`ifdef FETCH_PERF_EN
    localparam logic [31:0] PERF_AFTER_FIRST = 32'd2;
`else
    localparam logic [31:0] PERF_AFTER_FIRST = 32'd0;
`endif

    always #5 clk = ~clk;

    instr_fetch_unit #(.ADDR_W(8), .INSTR_W(16), .FQ_DEPTH(4), .RESET_PC(8'h00)) dut (
        .clk(clk), .reset(reset), .imem_en(imem_en), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc), .id_ready(id_ready),
        .perf_stall_cnt(perf_stall_cnt)
    );

    instr_fetch_unit #(.ADDR_W(8), .INSTR_W(16), .FQ_DEPTH(4), .RESET_PC(8'hFE)) dut_wrap (
        .clk(clk), .reset(reset), .imem_en(imem_en2), .imem_addr(imem_addr2),
        .imem_rdata(imem_rdata2), .redirect_valid(1'b0), .redirect_pc(8'h00),
        .id_valid(id_valid2), .id_instr(id_instr2), .id_pc(id_pc2), .id_ready(1'b1),
        .perf_stall_cnt(perf_stall_cnt2)
    );

    // Memory word i holds 0x1000 + i, one-cycle read latency.
    always @(posedge clk) begin
        if (imem_en)  imem_rdata  <= 16'h1000 + {8'h00, imem_addr};
        if (imem_en2) imem_rdata2 <= 16'h1000 + {8'h00, imem_addr2};
    end

    typedef struct {
        logic       rst;
        logic       rv;
        logic [7:0] rpc;
        logic       rdy;
        logic       chk_id;
        logic       en;
        logic [7:0] addr;
        logic       vld;
        logic [7:0] pc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic rv, input logic [7:0] rpc,
                                input logic rdy, input logic chk_id, input logic en,
                                input logic [7:0] addr, input logic vld, input logic [7:0] pc);
        vec_t v;
        v.rst = rst; v.rv = rv; v.rpc = rpc; v.rdy = rdy; v.chk_id = chk_id;
        v.en = en; v.addr = addr; v.vld = vld; v.pc = pc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        // Free run after reset.
        vecs.push_back(mk(1,0,8'h00,1, 1, 0,8'h00, 0,8'h00));
        vecs.push_back(mk(0,0,8'h00,1, 1, 1,8'h00, 0,8'h00));
        vecs.push_back(mk(0,0,8'h00,1, 1, 1,8'h01, 0,8'h00));
        vecs.push_back(mk(0,0,8'h00,1, 1, 1,8'h02, 1,8'h00));
        vecs.push_back(mk(0,0,8'h00,1, 1, 1,8'h03, 1,8'h01));
        vecs.push_back(mk(0,0,8'h00,1, 1, 1,8'h04, 1,8'h02));
        vecs.push_back(mk(0,0,8'h00,1, 1, 1,8'h05, 1,8'h03));
        // Decode stalls from cycle 2: queue fills, head holds, then drains.
        vecs.push_back(mk(1,0,8'h00,1, 0, 0,8'h00, 0,8'h00));
        vecs.push_back(mk(0,0,8'h00,1, 1, 1,8'h00, 0,8'h00));
        vecs.push_back(mk(0,0,8'h00,1, 1, 1,8'h01, 0,8'h00));
        vecs.push_back(mk(0,0,8'h00,0, 1, 1,8'h02, 1,8'h00));
        vecs.push_back(mk(0,0,8'h00,0, 1, 1,8'h03, 1,8'h00));
        vecs.push_back(mk(0,0,8'h00,0, 1, 0,8'h00, 1,8'h00));
        vecs.push_back(mk(0,0,8'h00,0, 1, 0,8'h00, 1,8'h00));
        vecs.push_back(mk(0,0,8'h00,0, 1, 0,8'h00, 1,8'h00));
        vecs.push_back(mk(0,0,8'h00,1, 1, 0,8'h00, 1,8'h00));
        vecs.push_back(mk(0,0,8'h00,1, 1, 1,8'h04, 1,8'h01));
        vecs.push_back(mk(0,0,8'h00,1, 1, 1,8'h05, 1,8'h02));
        vecs.push_back(mk(0,0,8'h00,1, 1, 1,8'h06, 1,8'h03));
        vecs.push_back(mk(0,0,8'h00,1, 1, 1,8'h07, 1,8'h04));
        vecs.push_back(mk(0,0,8'h00,1, 1, 1,8'h08, 1,8'h05));
        // Redirect with three queued entries and one request in flight.
        vecs.push_back(mk(1,0,8'h00,1, 0, 0,8'h00, 0,8'h00));
        vecs.push_back(mk(0,0,8'h00,1, 1, 1,8'h00, 0,8'h00));
        vecs.push_back(mk(0,0,8'h00,1, 1, 1,8'h01, 0,8'h00));
        vecs.push_back(mk(0,0,8'h00,0, 1, 1,8'h02, 1,8'h00));
        vecs.push_back(mk(0,0,8'h00,0, 1, 1,8'h03, 1,8'h00));
        vecs.push_back(mk(0,1,8'h40,0, 1, 0,8'h00, 1,8'h00));
        vecs.push_back(mk(0,0,8'h00,1, 1, 1,8'h40, 0,8'h00));
        vecs.push_back(mk(0,0,8'h00,1, 1, 1,8'h41, 0,8'h00));
        vecs.push_back(mk(0,0,8'h00,1, 1, 1,8'h42, 1,8'h40));
        vecs.push_back(mk(0,0,8'h00,1, 1, 1,8'h43, 1,8'h41));
        // Reset plus redirect with a full queue: reset wins.
        vecs.push_back(mk(1,0,8'h00,1, 0, 0,8'h00, 0,8'h00));
        vecs.push_back(mk(0,0,8'h00,1, 1, 1,8'h00, 0,8'h00));
        vecs.push_back(mk(0,0,8'h00,1, 1, 1,8'h01, 0,8'h00));
        vecs.push_back(mk(0,0,8'h00,0, 1, 1,8'h02, 1,8'h00));
        vecs.push_back(mk(0,0,8'h00,0, 1, 1,8'h03, 1,8'h00));
        vecs.push_back(mk(0,0,8'h00,0, 1, 0,8'h00, 1,8'h00));
        vecs.push_back(mk(1,1,8'h80,0, 0, 0,8'h00, 0,8'h00));
        vecs.push_back(mk(0,0,8'h00,1, 1, 1,8'h00, 0,8'h00));
        vecs.push_back(mk(0,0,8'h00,1, 1, 1,8'h01, 0,8'h00));
        vecs.push_back(mk(0,0,8'h00,1, 1, 1,8'h02, 1,8'h00));

        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            reset          = vecs[i].rst;
            redirect_valid = vecs[i].rv;
            redirect_pc    = vecs[i].rpc;
            id_ready       = vecs[i].rdy;
            @(negedge clk);
            chk($sformatf("row%0d imem_en", i), {31'd0, imem_en}, {31'd0, vecs[i].en});
            if (vecs[i].en || vecs[i].rst)
                chk($sformatf("row%0d imem_addr", i), {24'd0, imem_addr}, {24'd0, vecs[i].addr});
            if (vecs[i].chk_id) begin
                chk($sformatf("row%0d id_valid", i), {31'd0, id_valid}, {31'd0, vecs[i].vld});
                if (vecs[i].vld) begin
                    chk($sformatf("row%0d id_pc", i), {24'd0, id_pc}, {24'd0, vecs[i].pc});
                    chk($sformatf("row%0d id_instr", i), {16'd0, id_instr},
                        {16'd0, 16'h1000 + {8'h00, vecs[i].pc}});
                end
            end
            @(posedge clk);
            #1;
        end

        // Reset state, stall counter after the first instruction, PC wrap.
        reset = 1'b1;
        redirect_valid = 1'b0;
        id_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("reset id_valid", {31'd0, id_valid}, 32'd0);
        chk("reset id_pc", {24'd0, id_pc}, 32'd0);
        chk("reset id_instr", {16'd0, id_instr}, 32'd0);
        chk("reset perf", perf_stall_cnt, 32'd0);
        chk("reset wrap addr", {24'd0, imem_addr2}, 32'hFE);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("perf after first", perf_stall_cnt, PERF_AFTER_FIRST);
        chk("first id_valid", {31'd0, id_valid}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            logic [7:0] exp_pc;
            exp_pc = 8'hFE + 8'(k);
            chk($sformatf("wrap%0d id_valid", k), {31'd0, id_valid2}, 32'd1);
            chk($sformatf("wrap%0d id_pc", k), {24'd0, id_pc2}, {24'd0, exp_pc});
            chk($sformatf("wrap%0d id_instr", k), {16'd0, id_instr2},
                {16'd0, 16'h1000 + {8'h00, exp_pc}});
            @(posedge clk);
            #1;
        end
        chk("perf steady", perf_stall_cnt, PERF_AFTER_FIRST);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
